uart_rx_controller: RTL and testbench

UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

---
 rtl/uart_rx_controller.sv | 152 +++++++++++++++
 tb/tb_uart_rx_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_controller.sv
// UART receiver: 16x oversampled start/8 data/even parity/stop framing with
// a handshake towards the consumer and sticky overrun reporting.
module uart_rx_controller #(
    parameter int BAUD_DIV   = 326,
    parameter int OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        data_ack,
    output logic [10:0] packet,
    output logic        packet_completion,
    output logic        data_valid,
    output logic        parity_error,
    output logic        framing_error,
    output logic        overrun,
    output logic        busy
);

    localparam logic [11:0] TICK_LAST   = 12'(BAUD_DIV - 1);
    localparam logic [3:0]  SAMPLE_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]  SAMPLE_LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [1:0]  sync_reg;
    logic        rx_s;
    logic [11:0] tick_cnt_reg;
    logic        tick;
    logic [3:0]  sample_cnt_reg;
    logic [2:0]  bit_cnt_reg;
    logic        mid_hit;
    logic        bit_hit;
    logic [9:0]  frame_reg;
    logic [10:0] packet_reg;
    logic        data_valid_reg;
    logic        parity_error_reg;
    logic        framing_error_reg;
    logic        overrun_reg;

    assign rx_s    = sync_reg[1];
    assign tick    = (tick_cnt_reg == TICK_LAST);
    assign mid_hit = tick && (sample_cnt_reg == SAMPLE_MID);
    assign bit_hit = tick && (sample_cnt_reg == SAMPLE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!rx_s) state_next = START;
            START:   if (mid_hit) state_next = rx_s ? IDLE : DATA;
            DATA:    if (bit_hit && bit_cnt_reg == 3'd7) state_next = PARITY;
            PARITY:  if (bit_hit) state_next = STOP;
            STOP:    if (bit_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg          <= 2'b11;
            tick_cnt_reg      <= '0;
            sample_cnt_reg    <= '0;
            bit_cnt_reg       <= '0;
            frame_reg         <= '0;
            packet_reg        <= '0;
            data_valid_reg    <= 1'b0;
            parity_error_reg  <= 1'b0;
            framing_error_reg <= 1'b0;
            overrun_reg       <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], rx};

            if (state_reg == IDLE || tick) begin
                tick_cnt_reg <= '0;
            end else begin
                tick_cnt_reg <= tick_cnt_reg + 12'd1;
            end

            // The start-bit midpoint realigns the sample counter so that every
            // later bit is sampled at its own centre.
            if (state_reg == IDLE) begin
                sample_cnt_reg <= '0;
            end else if (tick) begin
                if (state_reg == START && sample_cnt_reg == SAMPLE_MID) begin
                    sample_cnt_reg <= '0;
                end else begin
                    sample_cnt_reg <= sample_cnt_reg + 4'd1;
                end
            end

            case (state_reg)
                START: begin
                    if (mid_hit && !rx_s) begin
                        frame_reg[0] <= 1'b0;
                        bit_cnt_reg  <= '0;
                    end
                end
                DATA: begin
                    if (bit_hit) begin
                        frame_reg[4'(bit_cnt_reg) + 4'd1] <= rx_s;
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    end
                end
                PARITY: begin
                    if (bit_hit) frame_reg[9] <= rx_s;
                end
                STOP: begin
                    // Frame assembled off to the side so packet only changes here.
                    if (bit_hit) packet_reg <= {rx_s, frame_reg};
                end
                default: ;
            endcase

            if (state_reg == DONE) begin
                parity_error_reg  <= (^packet_reg[8:1]) ^ packet_reg[9];
                framing_error_reg <= ~packet_reg[10];
                data_valid_reg    <= 1'b1;
                if (data_valid_reg && !data_ack) overrun_reg <= 1'b1;
            end else if (data_ack) begin
                data_valid_reg <= 1'b0;
            end
        end
    end

    assign packet            = packet_reg;
    assign packet_completion = (state_reg == DONE);
    assign data_valid        = data_valid_reg;
    assign parity_error      = parity_error_reg;
    assign framing_error     = framing_error_reg;
    assign overrun           = overrun_reg;
    assign busy              = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Self-checking bench for uart_rx_controller at BAUD_DIV=4 (64 clks per bit)
// using a frame-level reference model of the receiver's observable behaviour.
module tb_uart_rx_controller;

    localparam int BIT_CLKS = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        data_ack = 1'b0;
    logic [10:0] packet;
    logic        packet_completion;
    logic        data_valid;
    logic        parity_error;
    logic        framing_error;
    logic        overrun;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int comp_cnt = 0;
    int comp_cyc = 0;
    int start_cyc = 0;

    bit          dv_m = 1'b0;
    bit          ov_m = 1'b0;
    logic [10:0] exp_packet = '0;
    bit          exp_perr = 1'b0;
    bit          exp_ferr = 1'b0;

    uart_rx_controller #(
        .BAUD_DIV(4),
        .OVERSAMPLE(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .data_ack(data_ack),
        .packet(packet),
        .packet_completion(packet_completion),
        .data_valid(data_valid),
        .parity_error(parity_error),
        .framing_error(framing_error),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (packet_completion) begin
            comp_cnt <= comp_cnt + 1;
            comp_cyc <= cyc;
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        @(negedge clk);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = p;
        repeat (BIT_CLKS) @(negedge clk);
        rx = s;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
    endtask

    // Reference: what the consumer should see once a frame has been received.
    task automatic model_complete(input logic [7:0] d, input logic p, input logic s);
        exp_packet = {s, p, d, 1'b0};
        exp_perr   = (($countones(d) + int'(p)) % 2) != 0;
        exp_ferr   = !s;
        if (dv_m) ov_m = 1'b1;
        dv_m = 1'b1;
    endtask

    task automatic pulse_ack;
        @(negedge clk);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        dv_m = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if (packet !== 11'h000) begin bad++; $display("FAIL reset_packet got=%h want=000", packet); end
        total++; if ({data_valid, parity_error, framing_error, overrun} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {data_valid, parity_error, framing_error, overrun}); end
        total++; if ({busy, packet_completion} !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b want=00", {busy, packet_completion}); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_basic;
        int c0;
        int lat;
        c0 = comp_cnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        model_complete(8'hA5, 1'b0, 1'b1);
        lat = comp_cyc - start_cyc;
        total++; if (comp_cnt - c0 !== 1) begin bad++; $display("FAIL basic_pulses got=%0d want=1", comp_cnt - c0); end
        total++; if (packet !== 11'h54A) begin bad++; $display("FAIL basic_packet got=%h want=54a", packet); end
        total++; if (packet !== exp_packet) begin bad++; $display("FAIL basic_model got=%h want=%h", packet, exp_packet); end
        total++; if ({data_valid, parity_error, framing_error} !== 3'b100) begin
            bad++; $display("FAIL basic_flags got=%b want=100", {data_valid, parity_error, framing_error}); end
        total++; if (lat < 673 || lat > 677) begin bad++; $display("FAIL basic_latency got=%0d want=675+-2", lat); end
    endtask

    task automatic test_parity;
        pulse_ack();
        send_frame(8'h01, 1'b0, 1'b1);
        model_complete(8'h01, 1'b0, 1'b1);
        total++; if (parity_error !== exp_perr) begin bad++; $display("FAIL parity_bad got=%b want=%b", parity_error, exp_perr); end
        total++; if (packet[8:1] !== 8'h01) begin bad++; $display("FAIL parity_data got=%h want=01", packet[8:1]); end
        pulse_ack();
        send_frame(8'h03, 1'b0, 1'b1);
        model_complete(8'h03, 1'b0, 1'b1);
        total++; if (parity_error !== exp_perr) begin bad++; $display("FAIL parity_good got=%b want=%b", parity_error, exp_perr); end
        total++; if (packet !== exp_packet) begin bad++; $display("FAIL parity_packet got=%h want=%h", packet, exp_packet); end
    endtask

    task automatic test_framing;
        int c0;
        pulse_ack();
        c0 = comp_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        model_complete(8'h3C, 1'b0, 1'b0);
        total++; if (comp_cnt - c0 !== 1) begin bad++; $display("FAIL framing_pulses got=%0d want=1", comp_cnt - c0); end
        total++; if ({framing_error, data_valid} !== {exp_ferr, dv_m}) begin
            bad++; $display("FAIL framing_flags got=%b want=%b", {framing_error, data_valid}, {exp_ferr, dv_m}); end
        total++; if (packet !== exp_packet) begin bad++; $display("FAIL framing_packet got=%h want=%h", packet, exp_packet); end
        pulse_ack();
        c0 = comp_cnt;
        send_frame(8'h81, 1'b0, 1'b1);
        model_complete(8'h81, 1'b0, 1'b1);
        total++; if (comp_cnt - c0 !== 1) begin bad++; $display("FAIL framing_next_pulses got=%0d want=1", comp_cnt - c0); end
        total++; if ({packet, framing_error, parity_error} !== {exp_packet, exp_ferr, exp_perr}) begin
            bad++; $display("FAIL framing_next got=%h/%b/%b want=%h/%b/%b", packet, framing_error, parity_error,
                            exp_packet, exp_ferr, exp_perr); end
    endtask

    task automatic test_glitch;
        int c0;
        c0 = comp_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_start got=%b want=1", busy); end
        repeat (35) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b want=0", busy); end
        total++; if (comp_cnt !== c0) begin bad++; $display("FAIL glitch_pulses got=%0d want=%0d", comp_cnt, c0); end
        total++; if ({data_valid, overrun} !== {dv_m, ov_m}) begin
            bad++; $display("FAIL glitch_flags got=%b want=%b", {data_valid, overrun}, {dv_m, ov_m}); end
    endtask

    task automatic test_ack_same_clk;
        bit seen;
        pulse_ack();
        send_frame(8'h77, 1'b0, 1'b1);
        model_complete(8'h77, 1'b0, 1'b1);
        seen = 1'b0;
        fork
            send_frame(8'h0F, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 1000 && !seen; i++) begin
                    @(negedge clk);
                    if (packet_completion) seen = 1'b1;
                end
                if (seen) begin
                    data_ack = 1'b1;
                    @(negedge clk);
                    data_ack = 1'b0;
                end
            end
        join
        // Acknowledge and completion coincide: old packet consumed, new one pending.
        dv_m = 1'b0;
        model_complete(8'h0F, 1'b0, 1'b1);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL samclk_timeout got=%b want=1", seen); end
        total++; if ({data_valid, overrun} !== {dv_m, ov_m}) begin
            bad++; $display("FAIL samclk_flags got=%b want=%b", {data_valid, overrun}, {dv_m, ov_m}); end
        total++; if (packet !== exp_packet) begin bad++; $display("FAIL samclk_packet got=%h want=%h", packet, exp_packet); end
    endtask

    task automatic test_overrun;
        pulse_ack();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_pre got=%b want=0", overrun); end
        send_frame(8'h11, 1'b0, 1'b1);
        model_complete(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        model_complete(8'h22, 1'b0, 1'b1);
        total++; if (overrun !== ov_m) begin bad++; $display("FAIL ovr_set got=%b want=%b", overrun, ov_m); end
        total++; if (packet[8:1] !== 8'h22) begin bad++; $display("FAIL ovr_data got=%h want=22", packet[8:1]); end
        pulse_ack();
        total++; if ({data_valid, overrun} !== {dv_m, ov_m}) begin
            bad++; $display("FAIL ovr_ack got=%b want=%b", {data_valid, overrun}, {dv_m, ov_m}); end
    endtask

    task automatic test_reset_midframe;
        int c0;
        logic [7:0] d;
        d = 8'h5A;
        c0 = comp_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = d[4];
        repeat (BIT_CLKS / 2) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
        reset = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        dv_m = 1'b0;
        ov_m = 1'b0;
        total++; if ({busy, packet} !== 12'h000) begin bad++; $display("FAIL midrst_clear got=%b/%h want=0/000", busy, packet); end
        total++; if ({data_valid, overrun} !== 2'b00) begin bad++; $display("FAIL midrst_flags got=%b want=00", {data_valid, overrun}); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (comp_cnt !== c0) begin bad++; $display("FAIL midrst_pulses got=%0d want=%0d", comp_cnt, c0); end
        send_frame(d, 1'b0, 1'b1);
        model_complete(d, 1'b0, 1'b1);
        total++; if (comp_cnt - c0 !== 1) begin bad++; $display("FAIL midrst_next_pulses got=%0d want=1", comp_cnt - c0); end
        total++; if ({packet, parity_error, data_valid, overrun} !== {exp_packet, exp_perr, dv_m, ov_m}) begin
            bad++; $display("FAIL midrst_next got=%h/%b%b%b want=%h/%b%b%b", packet, parity_error, data_valid, overrun,
                            exp_packet, exp_perr, dv_m, ov_m); end
    endtask

    task automatic test_random;
        int c0;
        logic [7:0] d;
        logic p;
        logic s;
        for (int n = 0; n < 8; n++) begin
            d = 8'($urandom);
            p = (($countones(d) % 2) == 1);
            if ($urandom_range(0, 3) == 0) p = !p;
            s = ($urandom_range(0, 6) != 0);
            c0 = comp_cnt;
            send_frame(d, p, s);
            model_complete(d, p, s);
            total++; if (comp_cnt - c0 !== 1) begin bad++; $display("FAIL rnd%0d_pulses got=%0d want=1", n, comp_cnt - c0); end
            total++; if (packet !== exp_packet) begin bad++; $display("FAIL rnd%0d_packet got=%h want=%h", n, packet, exp_packet); end
            total++; if ({parity_error, framing_error} !== {exp_perr, exp_ferr}) begin
                bad++; $display("FAIL rnd%0d_errs got=%b want=%b", n, {parity_error, framing_error}, {exp_perr, exp_ferr}); end
            total++; if ({data_valid, overrun} !== {dv_m, ov_m}) begin
                bad++; $display("FAIL rnd%0d_flags got=%b want=%b", n, {data_valid, overrun}, {dv_m, ov_m}); end
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                total++; if (data_valid !== dv_m) begin bad++; $display("FAIL rnd%0d_ack got=%b want=%b", n, data_valid, dv_m); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_glitch();
        test_ack_same_clk();
        test_overrun();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
